// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative MIPS multiply/divide unit with private HI/LO.
//               MULT/MULTU use shift-add, DIV/DIVU use restoring division,
//               both over NB_DATA cycles. MFHI/MFLO/MTHI/MTLO are served
//               directly from HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
   parameter int NB_DATA  = 32,
   parameter int NB_FUNCT = 6,
   parameter int NB_COUNT = $clog2(NB_DATA)
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic [NB_DATA-1:0] i_instruction,
   input  logic [NB_DATA-1:0] i_rfile_rs,
   input  logic [NB_DATA-1:0] i_rfile_rt,
   input  logic               i_valid,
   input  logic               i_flush,
   output logic [NB_DATA-1:0] o_result,
   output logic               o_result_sel,
   output logic               o_busy,
   output logic               o_stall
);

   localparam logic [1:0] c_ST_IDLE = 2'd0;
   localparam logic [1:0] c_ST_MUL  = 2'd1;
   localparam logic [1:0] c_ST_DIV  = 2'd2;

   localparam logic [NB_FUNCT-1:0] c_MFHI  = 6'b010000;
   localparam logic [NB_FUNCT-1:0] c_MTHI  = 6'b010001;
   localparam logic [NB_FUNCT-1:0] c_MFLO  = 6'b010010;
   localparam logic [NB_FUNCT-1:0] c_MTLO  = 6'b010011;
   localparam logic [NB_FUNCT-1:0] c_MULT  = 6'b011000;
   localparam logic [NB_FUNCT-1:0] c_MULTU = 6'b011001;
   localparam logic [NB_FUNCT-1:0] c_DIV   = 6'b011010;
   localparam logic [NB_FUNCT-1:0] c_DIVU  = 6'b011011;

   logic [1:0]           r_state, w_next_state;
   logic                 r_busy;
   logic [NB_COUNT-1:0]  r_count;
   logic [NB_DATA-1:0]   r_hi, r_lo;
   logic [2*NB_DATA-1:0] r_acc;      // mul: {partial, multiplier}; div: {remainder, quotient}
   logic [NB_DATA-1:0]   r_opb;      // multiplicand or divisor magnitude
   logic                 r_neg_p, r_neg_r, r_dz;

   // ---------------- decode ----------------
   logic [NB_FUNCT-1:0] w_funct;
   logic w_rtype, w_mfhi, w_mthi, w_mflo, w_mtlo, w_mult, w_multu, w_div, w_divu;
   logic w_hilo_op, w_signed, w_start_mul, w_start_div, w_last, w_unused_bits;

   assign w_funct   = i_instruction[NB_FUNCT-1:0];
   assign w_rtype   = (i_instruction[NB_DATA-1 -: NB_FUNCT] == '0);
   assign w_mfhi    = w_rtype & (w_funct == c_MFHI);
   assign w_mthi    = w_rtype & (w_funct == c_MTHI);
   assign w_mflo    = w_rtype & (w_funct == c_MFLO);
   assign w_mtlo    = w_rtype & (w_funct == c_MTLO);
   assign w_mult    = w_rtype & (w_funct == c_MULT);
   assign w_multu   = w_rtype & (w_funct == c_MULTU);
   assign w_div     = w_rtype & (w_funct == c_DIV);
   assign w_divu    = w_rtype & (w_funct == c_DIVU);
   assign w_unused_bits = ^i_instruction[NB_DATA-NB_FUNCT-1:NB_FUNCT];

   // Reset participates so every combinational output is 0 while held in reset.
   assign w_hilo_op = i_reset & i_valid & ~i_flush &
                      (w_mfhi | w_mthi | w_mflo | w_mtlo | w_mult | w_multu | w_div | w_divu);
   assign w_signed    = w_mult | w_div;
   assign w_start_mul = w_hilo_op & (w_mult | w_multu) & ~r_busy;
   assign w_start_div = w_hilo_op & (w_div | w_divu) & ~r_busy;
   assign w_last      = (r_count == '0);

   logic              w_rs_neg, w_rt_neg;
   logic [NB_DATA-1:0] w_abs_rs, w_abs_rt;
   assign w_rs_neg = w_signed & i_rfile_rs[NB_DATA-1];
   assign w_rt_neg = w_signed & i_rfile_rt[NB_DATA-1];
   assign w_abs_rs = w_rs_neg ? -i_rfile_rs : i_rfile_rs;
   assign w_abs_rt = w_rt_neg ? -i_rfile_rt : i_rfile_rt;

   // ---------------- one iteration step ----------------
   logic [NB_DATA:0]     w_mul_sum, w_div_part, w_div_trial;
   logic [2*NB_DATA-1:0] w_mul_next, w_div_next, w_prod;
   logic [NB_DATA-1:0]   w_quot, w_rem, w_div_hi, w_div_lo;

   assign w_mul_sum   = {1'b0, r_acc[2*NB_DATA-1:NB_DATA]} + {1'b0, r_opb};
   assign w_mul_next  = r_acc[0] ? {w_mul_sum, r_acc[NB_DATA-1:1]}
                                 : {1'b0, r_acc[2*NB_DATA-1:1]};
   assign w_prod      = r_neg_p ? -w_mul_next : w_mul_next;

   // Shifted remainder needs one extra bit before the trial subtraction.
   assign w_div_part  = r_acc[2*NB_DATA-1:NB_DATA-1];
   assign w_div_trial = w_div_part - {1'b0, r_opb};
   assign w_div_next  = w_div_trial[NB_DATA]
                        ? {w_div_part[NB_DATA-1:0], r_acc[NB_DATA-2:0], 1'b0}
                        : {w_div_trial[NB_DATA-1:0], r_acc[NB_DATA-2:0], 1'b1};
   assign w_quot      = w_div_next[NB_DATA-1:0];
   assign w_rem       = w_div_next[2*NB_DATA-1:NB_DATA];
   // Divide by zero naturally leaves rem = |rs|; only the quotient sign must be suppressed.
   assign w_div_lo    = r_dz ? '1 : (r_neg_p ? -w_quot : w_quot);
   assign w_div_hi    = r_neg_r ? -w_rem : w_rem;

   // State register and registered busy flag
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= c_ST_IDLE;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_busy  <= (w_next_state != c_ST_IDLE);
      end
   end

   // Next-state logic: start from IDLE, leave on last iteration or flush
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_ST_IDLE: begin
            if (w_start_mul)      w_next_state = c_ST_MUL;
            else if (w_start_div) w_next_state = c_ST_DIV;
         end
         c_ST_MUL, c_ST_DIV: begin
            if (i_flush || w_last) w_next_state = c_ST_IDLE;
         end
         default: w_next_state = c_ST_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      o_busy       = r_busy;
      o_stall      = r_busy & w_hilo_op;
      o_result_sel = w_hilo_op & (w_mfhi | w_mflo) & ~r_busy;
      o_result     = '0;
      if (o_result_sel) o_result = w_mfhi ? r_hi : r_lo;
   end

   // Datapath: operand latch, iteration, HI/LO writeback and MTHI/MTLO
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_count <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_acc   <= '0;
         r_opb   <= '0;
         r_neg_p <= 1'b0;
         r_neg_r <= 1'b0;
         r_dz    <= 1'b0;
      end else if (r_state == c_ST_IDLE) begin
         if (w_start_mul || w_start_div) begin
            r_acc   <= {{NB_DATA{1'b0}}, (w_start_mul ? w_abs_rt : w_abs_rs)};
            r_opb   <= w_start_mul ? w_abs_rs : w_abs_rt;
            r_neg_p <= w_rs_neg ^ w_rt_neg;
            r_neg_r <= w_rs_neg;
            r_dz    <= w_start_div & (i_rfile_rt == '0);
            r_count <= NB_COUNT'(NB_DATA-1);
         end else if (w_hilo_op) begin
            if (w_mthi) r_hi <= i_rfile_rs;
            if (w_mtlo) r_lo <= i_rfile_rs;
         end
      end else if (!i_flush) begin
         r_acc <= (r_state == c_ST_MUL) ? w_mul_next : w_div_next;
         if (w_last) begin
            if (r_state == c_ST_MUL) begin
               r_hi <= w_prod[2*NB_DATA-1:NB_DATA];
               r_lo <= w_prod[NB_DATA-1:0];
            end else begin
               r_hi <= w_div_hi;
               r_lo <= w_div_lo;
            end
         end else begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the EX stage of the pipelined MIPS core. It decodes the same R-type instruction word that `alu_ctrl` receives from the ID/EX latch, and executes MULT/MULTU/DIV/DIVU over 32 cycles into private HI/LO registers. It also serves MFHI/MFLO/MTHI/MTLO. Its read result is muxed with the `alu_ctrl` result ahead of the EX/MEM latch, and its stall request goes to the hazard unit.

## Interface
- `NB_DATA`, 32: operand/result width; HI and LO are NB_DATA each.
- `NB_FUNCT`, 6: width of the funct and opcode fields.
- `NB_COUNT`, $clog2(NB_DATA): iteration counter width.

Ports:
- `i_clock`  in  1  the single clock; all state updates on its rising edge.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_instruction`  in  NB_DATA  EX-stage instruction; opcode [31:26], funct [5:0].
- `i_rfile_rs`  in  NB_DATA  rs operand (dividend / multiplicand / MTxx source).
- `i_rfile_rt`  in  NB_DATA  rt operand (divisor / multiplier).
- `i_valid`  in  1  EX holds a real instruction (0 = bubble).
- `i_flush`  in  1  kill the EX instruction and abort any operation in progress.
- `o_result`  out  NB_DATA  HI for MFHI, LO for MFLO, else 0.
- `o_result_sel`  out  1  1 when the EX/MEM mux must take `o_result`.
- `o_busy`  out  1  an iterative operation is in progress.
- `o_stall`  out  1  the hazard unit must freeze IF/ID/EX.

## Operation
- Decode applies only when opcode == 6'b000000. Funct codes: MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
- `hilo_op` = i_valid & !i_flush & funct is any of the eight codes above.
- **FSM states:** IDLE, MUL, DIV.
  - IDLE→MUL on MULT/MULTU when `hilo_op` is true and `o_busy` is 0.
  - IDLE→DIV on DIV/DIVU under the same condition.
  - MUL/DIV→IDLE after the iteration with counter == 0, writing HI/LO on that edge.
  - MUL/DIV→IDLE on `i_flush`, with no HI/LO write.
- **Operand latch on start:**
  - Operands are captured at the accepting edge, so later changes on the rs/rt inputs are ignored.
  - Signed ops latch |rs| and |rt| plus `neg_p` = rs[31]^rt[31] and `neg_r` = rs[31]. Unsigned ops set both flags to 0.
  - Counter loads NB_DATA-1.
- **Multiply:** one shift-add step per cycle on a 2·NB_DATA accumulator. The final product is negated (two's complement, 64-bit) when `neg_p`. HI = product[63:32], LO = product[31:0].
- **Divide:** restoring division, one quotient bit per cycle. LO = quotient, negated if `neg_p`. HI = remainder, negated if `neg_r`.
- **Divide by zero:** no exception and the same 32-cycle latency. LO = 32'hFFFFFFFF and HI = rs for both signed and unsigned.
- **Signed overflow:** 0x80000000 / -1 gives LO = 0x80000000, HI = 0.
- **MTHI/MTLO:** write rs into HI/LO at the edge when `hilo_op` is true and `o_busy` is 0.
- **MFHI/MFLO:** combinational. `o_result_sel` = `hilo_op` & (MFHI|MFLO) & !`o_busy`.
- **Stall:** `o_stall` = `o_busy` & `hilo_op`. Instructions that do not use HI/LO proceed while the unit is busy.
- **Flush in IDLE:** the instruction is not started and HI/LO are unchanged. When flush and start coincide, flush wins.
- **Reset (async, also mid-operation):** state IDLE, counter 0, HI = LO = 0, accumulators 0, `o_busy` 0. All outputs go to 0 immediately.

## Timing
- `o_busy` is a registered output equal to (state != IDLE).
- `o_busy` rises on the edge that accepts a MULT/DIV. It stays high for exactly NB_DATA (32) cycles and falls on the edge that writes HI/LO.
- An MFHI/MFLO presented in the cycle `o_busy` falls reads the new values. A back-to-back MFLO after MULT stalls 32 cycles.
- MTHI/MTLO take effect at the next edge, so a following MFHI sees the new value (zero-cycle bypass not required).
- A second MULT/DIV issued while busy stalls. It is accepted on the first cycle with `o_busy` = 0.
- `o_stall` and `o_result` are combinational from the inputs and registered state, with no extra latency.

## Test plan
- MULT rs=7, rt=0xFFFFFFFD → `o_busy` high for 32 cycles; then MFHI = 0xFFFFFFFF and MFLO = 0xFFFFFFEB.
- MULTU rs = rt = 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001. A MULT issued mid-operation asserts `o_stall` until `o_busy` falls.
- DIV rs=0xFFFFFFF9 (-7), rt=2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU with the same operands → LO = 0x7FFFFFFC, HI = 1.
- DIV rs=0x12345678, rt=0 → after 32 cycles LO = 0xFFFFFFFF, HI = 0x12345678. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- MTHI rs=0xA5A5A5A5, then MFHI next cycle → `o_result` = 0xA5A5A5A5 with `o_result_sel` = 1. An ADD issued during a busy MULT → `o_stall` = 0.
- Flush at iteration 10 of a MULT → IDLE next edge, HI/LO hold prior values. An async `i_reset` = 0 mid-DIV → `o_busy` = 0 and HI = LO = 0 immediately, with no glitch after release.
